udiv_12_4_seq: RTL and testbench

Sequential unsigned restoring divider that inverts the 8x4 array multiplier: it divides a 12-bit unsigned dividend by a 4-bit unsigned divisor and returns an 8-bit quotient and a 4-bit remainder. The block retires one quotient bit per clock using a start/done handshake. It sits beside the multiplier library as the arithmetic-inverse block, and it is used for product-range checks and for scaling back down.

---
 rtl/udiv_12_4_seq.sv | 129 ++++++++++++
 tb/tb_udiv_12_4_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/udiv_12_4_seq.sv
// udiv_12_4_seq: sequential unsigned restoring divider, 12-bit / 4-bit.
// Retires one quotient bit per clock after a START/DONE handshake.
//
// Ports:
//   CLK   - clock, rising edge
//   RST   - asynchronous active-high reset
//   START - request pulse, sampled only while BUSY=0
//   DVD   - 12-bit dividend, captured on accepted START
//   DVS   - 4-bit divisor, captured on accepted START
//   Q     - 8-bit quotient register
//   R     - 4-bit remainder register
//   BUSY  - high in CALC and FIN
//   DONE  - one-cycle pulse while Q/R/DZ/OVF are valid (FIN state)
//   DZ    - divide-by-zero flag for the last operation
//   OVF   - quotient-overflow flag for the last operation
//
// Optional feature: define UDIV_OVF_CHECK_EN to compile in the
// DVD[11:8] >= DVS overflow precheck. Without it OVF is tied to 0 and the
// caller must guarantee DVD < DVS*256.

module udiv_12_4_seq (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [11:0] DVD,
  input  logic [3:0]  DVS,
  output logic [7:0]  Q,
  output logic [3:0]  R,
  output logic        BUSY,
  output logic        DONE,
  output logic        DZ,
  output logic        OVF
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0] state;
  logic [3:0] pr;
  logic [3:0] dvs_r;
  logic [7:0] sh;
  logic [2:0] cnt;

  logic [4:0] t;
  logic [4:0] diff;
  logic       qbit;
  logic [3:0] pr_next;

`ifdef UDIV_OVF_CHECK_EN
  logic ovf_r;
  assign OVF = ovf_r;
`else
  assign OVF = 1'b0;
`endif

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  // Only the low 4 bits of the difference are kept as the new partial remainder.
  always_comb begin
    t       = {pr, sh[7]};
    diff    = t - {1'b0, dvs_r};
    qbit    = (t >= {1'b0, dvs_r});
    pr_next = qbit ? diff[3:0] : t[3:0];
  end

  assign BUSY = (state != S_IDLE);
  assign DONE = (state == S_FIN);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      pr    <= '0;
      dvs_r <= '0;
      sh    <= '0;
      cnt   <= '0;
      Q     <= '0;
      R     <= '0;
      DZ    <= 1'b0;
`ifdef UDIV_OVF_CHECK_EN
      ovf_r <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            dvs_r <= DVS;
            pr    <= DVD[11:8];
            sh    <= DVD[7:0];
            cnt   <= 3'd7;
            DZ    <= 1'b0;
`ifdef UDIV_OVF_CHECK_EN
            ovf_r <= 1'b0;
`endif
            if (DVS == '0) begin
              DZ    <= 1'b1;
              Q     <= '1;
              R     <= DVD[3:0];
              state <= S_FIN;
            end
`ifdef UDIV_OVF_CHECK_EN
            else if (DVD[11:8] >= DVS) begin
              ovf_r <= 1'b1;
              Q     <= '1;
              R     <= '1;
              state <= S_FIN;
            end
`endif
            else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          pr  <= pr_next;
          sh  <= {sh[6:0], 1'b0};
          Q   <= {Q[6:0], qbit};
          cnt <= cnt - 3'd1;
          if (cnt == 3'd0) begin
            R     <= pr_next;
            state <= S_FIN;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udiv_12_4_seq.sv
// Testbench for udiv_12_4_seq: directed vector table, hand-written corner
// sequences (ignored START, divide-by-zero, reset abort) and a random sweep
// over all nonzero divisors with back-to-back operations.

module tb_udiv_12_4_seq;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [11:0] DVD;
  logic [3:0]  DVS;
  logic [7:0]  Q;
  logic [3:0]  R;
  logic        BUSY;
  logic        DONE;
  logic        DZ;
  logic        OVF;

  int unsigned n_cmp;
  int unsigned n_bad;

  udiv_12_4_seq dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .DVD   (DVD),
    .DVS   (DVS),
    .Q     (Q),
    .R     (R),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .DZ    (DZ),
    .OVF   (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [11:0] dvd;
    logic [3:0]  dvs;
    logic [7:0]  q;
    logic [3:0]  r;
    logic        dz;
    logic        ovf;
    int          lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issue one operation; lat counts edges from the START sample (edge 0)
  // through the edge after which DONE is seen. Returns once back in IDLE.
  task automatic run_op(input logic [11:0] a, input logic [3:0] b,
                        output int lat, output logic [7:0] q,
                        output logic [3:0] r, output logic dz, output logic ovf);
    @(negedge CLK);
    DVD   = a;
    DVS   = b;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    lat = 1;
    while (!DONE && lat < 40) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    q   = Q;
    r   = R;
    dz  = DZ;
    ovf = OVF;
    if (!DONE) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: DONE not seen for %0d/%0d", a, b);
    end
    @(posedge CLK);
    #1;
  endtask

  vec_t        vecs[12];
  int          lat;
  logic [7:0]  q;
  logic [3:0]  r;
  logic        dz;
  logic        ovf;
  int          dvd_i;
  int          seen_done;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    START = 1'b0;
    DVD   = '0;
    DVS   = '0;
    RST   = 1'b1;

    vecs[0]  = '{12'd1530, 4'd6,  8'd255, 4'd0,  1'b0, 1'b0, 9};
    vecs[1]  = '{12'd100,  4'd7,  8'd14,  4'd2,  1'b0, 1'b0, 9};
    vecs[2]  = '{12'h123,  4'd0,  8'hFF,  4'h3,  1'b1, 1'b0, 1};
    vecs[3]  = '{12'd900,  4'd9,  8'd100, 4'd0,  1'b0, 1'b0, 9};
    vecs[4]  = '{12'd1000, 4'd4,  8'd250, 4'd0,  1'b0, 1'b0, 9};
    vecs[5]  = '{12'd255,  4'd15, 8'd17,  4'd0,  1'b0, 1'b0, 9};
    vecs[6]  = '{12'd3839, 4'd15, 8'd255, 4'd14, 1'b0, 1'b0, 9};
    vecs[7]  = '{12'd0,    4'd5,  8'd0,   4'd0,  1'b0, 1'b0, 9};
    vecs[8]  = '{12'd7,    4'd8,  8'd0,   4'd7,  1'b0, 1'b0, 9};
    vecs[9]  = '{12'd2000, 4'd13, 8'd153, 4'd11, 1'b0, 1'b0, 9};
    vecs[10] = '{12'hFFF,  4'd0,  8'hFF,  4'hF,  1'b1, 1'b0, 1};
`ifdef UDIV_OVF_CHECK_EN
    vecs[11] = '{12'hFFF,  4'd3,  8'hFF,  4'hF,  1'b0, 1'b1, 1};
`else
    vecs[11] = '{12'hFFF,  4'd3,  8'hFF,  4'd2,  1'b0, 1'b0, 9};
`endif

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_q", int'(Q), 0);
    check("rst_r", int'(R), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_dz", int'(DZ), 0);
    check("rst_ovf", int'(OVF), 0);
    @(negedge CLK);
    RST = 1'b0;

    // Directed table, issued back to back
    foreach (vecs[i]) begin
      run_op(vecs[i].dvd, vecs[i].dvs, lat, q, r, dz, ovf);
      check($sformatf("v%0d_q", i), int'(q), int'(vecs[i].q));
      check($sformatf("v%0d_r", i), int'(r), int'(vecs[i].r));
      check($sformatf("v%0d_dz", i), int'(dz), int'(vecs[i].dz));
      check($sformatf("v%0d_ovf", i), int'(ovf), int'(vecs[i].ovf));
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_idle", i), int'(BUSY), 0);
    end

    // START pulses at edges 3 and 5 during 100/7 must be ignored
    @(negedge CLK);
    DVD = 12'd100; DVS = 4'd7; START = 1'b1;
    @(posedge CLK);                 // edge 0
    #1;
    START = 1'b0;
    check("ign_busy", int'(BUSY), 1);
    lat = 1;
    while (!DONE && lat < 40) begin
      @(negedge CLK);
      if (lat == 3 || lat == 5) begin
        DVD = 12'd999; DVS = 4'd1; START = 1'b1;
      end else begin
        START = 1'b0;
      end
      @(posedge CLK);
      #1;
      lat++;
    end
    START = 1'b0;
    check("ign_done", int'(DONE), 1);
    check("ign_lat", lat, 9);
    check("ign_q", int'(Q), 14);
    check("ign_r", int'(R), 2);
    @(posedge CLK);
    #1;
    check("ign_idle", int'(BUSY), 0);
    check("ign_hold_q", int'(Q), 14);

    // Reset mid-operation: 900/9 aborted around edge 4
    @(negedge CLK);
    DVD = 12'd900; DVS = 4'd9; START = 1'b1;
    @(posedge CLK);                 // edge 0
    #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);      // edges 1..3
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("abort_q", int'(Q), 0);
    check("abort_r", int'(R), 0);
    check("abort_busy", int'(BUSY), 0);
    check("abort_done", int'(DONE), 0);
    check("abort_dz", int'(DZ), 0);
    check("abort_ovf", int'(OVF), 0);
    @(negedge CLK);
    RST = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge CLK);
      #1;
      if (DONE) seen_done = 1;
    end
    check("abort_no_done", seen_done, 0);
    run_op(12'd900, 4'd9, lat, q, r, dz, ovf);
    check("after_abort_q", int'(q), 100);
    check("after_abort_r", int'(r), 0);
    check("after_abort_lat", lat, 9);

    // Sweep every nonzero divisor with random in-range dividends, back to back
    for (int d = 1; d <= 15; d++) begin
      for (int k = 0; k < 3; k++) begin
        dvd_i = (k == 0) ? d * 256 - 1 : int'($urandom_range(0, d * 256 - 1));
        run_op(12'(dvd_i), 4'(d), lat, q, r, dz, ovf);
        check($sformatf("sw_%0d_%0d_eq", dvd_i, d), int'(q) * d + int'(r), dvd_i);
        check($sformatf("sw_%0d_%0d_rlt", dvd_i, d), int'(int'(r) < d), 1);
        check($sformatf("sw_%0d_%0d_lat", dvd_i, d), lat, 9);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
